srambo_2: RTL and testbench

Parametrised successor to the first-generation SRAM expansion CPLD for 8-bit Atari XL/XE machines. It snoops CPU writes to the PIA, so it holds its own PORTB shadow and no longer needs the PB pins. It generates the linear SRAM address for main and extended RAM. It decodes OS, BASIC, self-test, I/O and cartridge space from the shadowed state. Bank depth and mode are configurable, and an optional Axlon-style bank register is supported.

---
 rtl/srambo_pkg.sv | 39 +++
 rtl/srambo_2_pia_portb_shadow.sv | 44 ++++
 rtl/srambo_2.sv | 146 ++++++++++++++
 tb/tb_srambo_2.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srambo_pkg.sv
// Shared constants for srambo_2: mode encodings, PIA and Axlon addresses, decode
// blocks and the per-mode mapping of PORTB bits onto bank-number bits.
package srambo_pkg;

  typedef enum logic [1:0] {
    MODE_RAMBO     = 2'd0,
    MODE_COMPY     = 2'd1,
    MODE_AXLON     = 2'd2,
    MODE_RAMBO_ALT = 2'd3
  } mode_e;

  localparam logic [15:0] PIA_PORTB_ADDR = 16'hD301;
  localparam logic [15:0] PIA_PBCTL_ADDR = 16'hD303;

  // $CFC0-$CFFF is one 64-byte page: match addr[15:6]
  localparam logic [9:0] AXLON_PAGE = 10'h33F;

  localparam logic [1:0] WINDOW_BASE  = 2'b01;     // $4000-$7FFF, addr[15:14]
  localparam logic [3:0] OS_C_BLK     = 4'hC;      // $C000-$CFFF, addr[15:12]
  localparam logic [4:0] IO_BLK       = 5'b11010;  // $D000-$D7FF, addr[15:11]
  localparam logic [4:0] MATH_BLK     = 5'b11011;  // $D800-$DFFF, addr[15:11]
  localparam logic [4:0] SELFTEST_BLK = 5'b01010;  // $5000-$57FF, addr[15:11]
  localparam logic [2:0] OS_E_BLK     = 3'b111;    // $E000-$FFFF, addr[15:13]
  localparam logic [2:0] CART_A_BLK   = 3'b101;    // $A000-$BFFF, addr[15:13]
  localparam logic [2:0] CART_8_BLK   = 3'b100;    // $8000-$9FFF, addr[15:13]

  // Entry i names the PORTB bit that becomes bank bit i
  localparam logic [3:0][2:0] RAMBO_BANK_ORDER = {3'd6, 3'd5, 3'd3, 3'd2};
  localparam logic [3:0][2:0] COMPY_BANK_ORDER = {3'd7, 3'd6, 3'd3, 3'd2};

  function automatic logic [3:0] pick_bank(input logic [7:0] pb,
                                           input logic [3:0][2:0] order);
    logic [3:0] b;
    b = '0;
    for (int i = 0; i < 4; i++) b[i] = pb[order[i]];
    return b;
  endfunction

endpackage

// File: rtl/srambo_2_pia_portb_shadow.sv
// Snooped copy of the PIA port-B registers (ORB, DDRB, PBCTL) updated on the
// falling edge of o2; undriven port lines read high in the effective portb.
module pia_portb_shadow
  import srambo_pkg::*;
(
  input  logic        o2,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  data,
  input  logic        n_we,
  input  logic        n_ref,
  input  logic        halt,
  output logic        snoop_wr,
  output logic [7:0]  portb
);

  logic [7:0] orb;
  logic [7:0] ddrb;
  logic [7:0] pbctl;

  // Refresh and ANTIC cycles never carry a CPU write
  assign snoop_wr = n_ref & halt & ~n_we;

  always_ff @(negedge o2) begin
    if (reset) begin
      orb   <= '0;
      ddrb  <= '0;
      pbctl <= '0;
    end else if (snoop_wr) begin
      if (addr == PIA_PBCTL_ADDR) pbctl <= data;
      if (addr == PIA_PORTB_ADDR) begin
        if (pbctl[2]) orb  <= data;
        else          ddrb <= data;
      end
    end
  end

  assign portb = orb | ~ddrb;

  // Only the register-select bit of PBCTL steers anything here
  logic unused_pbctl;
  assign unused_pbctl = ^{pbctl[7:3], pbctl[1:0]};

endmodule

// File: rtl/srambo_2.sv
// SRAM expansion controller: PORTB-shadowed banking, ROM hold bits and memory decode.
// SRAMBO_AXLON_EN adds the Axlon bank register at $CFC0-$CFFF used in mode 2.
module srambo_2
  import srambo_pkg::*;
#(
  parameter int BANK_BITS = 4,
  parameter int RAM_AW    = 15 + BANK_BITS
) (
  input  logic              o2,
  input  logic              reset,
  input  logic [15:0]       addr,
  input  logic [7:0]        data,
  input  logic              n_we,
  input  logic              n_ref,
  input  logic              halt,
  input  logic [1:0]        mode,
  input  logic              rd4,
  input  logic              rd5,
  input  logic              n_mpd,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              bank_hit,
  output logic [7:0]        portb,
  output logic              n_os,
  output logic              n_basic,
  output logic              n_io,
  output logic              n_s4,
  output logic              n_s5,
  output logic              n_ci
);

`ifdef SRAMBO_AXLON_EN
  localparam int MAX_BANK_BITS = 8;
`else
  localparam int MAX_BANK_BITS = 4;
`endif

  if (BANK_BITS < 2 || BANK_BITS > MAX_BANK_BITS) begin : g_bank_bits_check
    $error("srambo_2: BANK_BITS out of range for this build");
  end

  logic snoop_wr;

  pia_portb_shadow u_shadow (
    .o2       (o2),
    .reset    (reset),
    .addr     (addr),
    .data     (data),
    .n_we     (n_we),
    .n_ref    (n_ref),
    .halt     (halt),
    .snoop_wr (snoop_wr),
    .portb    (portb)
  );

  logic halt_r;
  logic os_r, basic_r, st_r;
  logic os_hold, basic_hold, st_hold;
  logic reload;

  // In Compy Shop pb4 and pb5 are bank enables, so ROM bits track portb only
  // while both are off; the registers carry the last unbanked state.
  assign reload     = portb[4] & (portb[5] | (mode != MODE_COMPY));
  assign os_hold    = reload ? portb[0] : os_r;
  assign basic_hold = reload ? portb[1] : basic_r;
  assign st_hold    = reload ? portb[7] : st_r;

  always_ff @(negedge o2) begin
    if (reset) begin
      halt_r  <= 1'b1;
      os_r    <= 1'b1;
      basic_r <= 1'b1;
      st_r    <= 1'b1;
    end else begin
      halt_r  <= halt;
      os_r    <= os_hold;
      basic_r <= basic_hold;
      st_r    <= st_hold;
    end
  end

`ifdef SRAMBO_AXLON_EN
  localparam logic [7:0] AXL_MASK = 8'((16'd1 << BANK_BITS) - 16'd1);
  logic [7:0] axl_r;

  always_ff @(negedge o2) begin
    if (reset)                                 axl_r <= '0;
    else if (snoop_wr && addr[15:6] == AXLON_PAGE) axl_r <= data & AXL_MASK;
  end
`endif

  logic                 bank_en;
  logic [7:0]           bank_full;
  logic [BANK_BITS-1:0] bank;

  always_comb begin
    bank_en   = ~portb[4];
    bank_full = '0;
    case (mode)
      MODE_COMPY: begin
        bank_en        = (~portb[4] & halt_r) | (~portb[5] & ~halt_r);
        bank_full[3:0] = pick_bank(portb, COMPY_BANK_ORDER);
      end
`ifdef SRAMBO_AXLON_EN
      MODE_AXLON: begin
        bank_en   = |axl_r;
        bank_full = axl_r;
      end
`endif
      default: bank_full[3:0] = pick_bank(portb, RAMBO_BANK_ORDER);
    endcase
  end

  assign bank     = bank_full[BANK_BITS-1:0];
  assign bank_hit = (addr[15:14] == WINDOW_BASE) & bank_en;

  logic unused_bank;
  assign unused_bank = ^bank_full;

  always_comb begin
    ram_addr = '0;
    if (bank_hit) ram_addr = {1'b1, bank, addr[13:0]};
    else          ram_addr[15:0] = addr;
  end

  logic os_sel, basic_sel, io_sel, s4_sel, s5_sel;

  always_comb begin
    os_sel    = n_ref & os_hold &
                ((addr[15:12] == OS_C_BLK) |
                 ((addr[15:11] == MATH_BLK) & n_mpd) |
                 (addr[15:13] == OS_E_BLK) |
                 ((addr[15:11] == SELFTEST_BLK) & ~st_hold & ~bank_hit));
    basic_sel = n_ref & (addr[15:13] == CART_A_BLK) & ~basic_hold & ~rd5;
    io_sel    = n_ref & (addr[15:11] == IO_BLK);
    s4_sel    = n_ref & rd4 & (addr[15:13] == CART_8_BLK);
    s5_sel    = n_ref & rd5 & (addr[15:13] == CART_A_BLK);
  end

  assign n_os    = ~os_sel;
  assign n_basic = ~basic_sel;
  assign n_io    = ~io_sel;
  assign n_s4    = ~s4_sel;
  assign n_s5    = ~s5_sel;
  assign n_ci    = ~(os_sel | basic_sel | io_sel | s4_sel | s5_sel | ~n_ref);

endmodule

// File: tb/tb_srambo_2.sv
// Scoreboard bench for srambo_2: expectations are queued with each bus cycle and
// compared against the outputs mid-cycle (rising o2), away from the falling commit edge.
module tb_srambo_2;

`ifdef SRAMBO_AXLON_EN
  localparam int BB = 8;
`else
  localparam int BB = 4;
`endif
  localparam int AW = 15 + BB;

  localparam int F_RA = 0, F_HIT = 1, F_PB = 2, F_OS = 3, F_BAS = 4,
                 F_IO = 5, F_S4 = 6, F_S5 = 7, F_CI = 8;

  logic          o2 = 1'b0;
  logic          reset;
  logic [15:0]   addr;
  logic [7:0]    data;
  logic          n_we, n_ref, halt;
  logic [1:0]    mode;
  logic          rd4, rd5, n_mpd;
  logic [AW-1:0] ram_addr;
  logic          bank_hit;
  logic [7:0]    portb;
  logic          n_os, n_basic, n_io, n_s4, n_s5, n_ci;

  always #5 o2 = ~o2;

  srambo_2 #(.BANK_BITS(BB)) dut (
    .o2(o2), .reset(reset), .addr(addr), .data(data), .n_we(n_we),
    .n_ref(n_ref), .halt(halt), .mode(mode), .rd4(rd4), .rd5(rd5),
    .n_mpd(n_mpd), .ram_addr(ram_addr), .bank_hit(bank_hit), .portb(portb),
    .n_os(n_os), .n_basic(n_basic), .n_io(n_io), .n_s4(n_s4), .n_s5(n_s5),
    .n_ci(n_ci)
  );

  typedef struct {
    string       tag;
    int          f;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else             n_pass++;
  endtask

  function automatic logic [31:0] observe(input int f);
    case (f)
      F_RA:    return 32'(ram_addr);
      F_HIT:   return 32'(bank_hit);
      F_PB:    return 32'(portb);
      F_OS:    return 32'(n_os);
      F_BAS:   return 32'(n_basic);
      F_IO:    return 32'(n_io);
      F_S4:    return 32'(n_s4);
      F_S5:    return 32'(n_s5);
      default: return 32'(n_ci);
    endcase
  endfunction

  function automatic logic [31:0] ra_bank(input int bank, input logic [15:0] a);
    return (32'd1 << (14 + BB)) | (32'(bank) << 14) | 32'(a[13:0]);
  endfunction

  task automatic expect_val(input string tag, input int f, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.f = f; e.v = v;
    sb.push_back(e);
  endtask

  // Compare mid-cycle, then let the falling edge commit and re-drive just after it
  task automatic step();
    exp_t e;
    @(posedge o2);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.f), e.v);
    end
    @(negedge o2);
    #1;
  endtask

  task automatic bus(input logic [15:0] a, input logic [7:0] d, input logic wr);
    addr = a; data = d; n_we = ~wr; n_ref = 1'b1; halt = 1'b1; reset = 1'b0;
  endtask

  task automatic wr_cyc(input logic [15:0] a, input logic [7:0] d);
    bus(a, d, 1'b1);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    addr = '0; data = '0; n_we = 1'b1; n_ref = 1'b1; halt = 1'b1;
    mode = 2'd0; rd4 = 1'b0; rd5 = 1'b0; n_mpd = 1'b1; reset = 1'b1;
    repeat (2) @(negedge o2);
    #1;

    // Reset state
    bus(16'h4000, 8'h00, 1'b0);
    expect_val("rst_portb", F_PB, 32'hFF);
    expect_val("rst_hit", F_HIT, 32'd0);
    expect_val("rst_ra", F_RA, 32'h04000);
    step();
    bus(16'hE000, 8'h00, 1'b0);
    expect_val("rst_os", F_OS, 32'd0);
    expect_val("rst_ci", F_CI, 32'd0);
    step();
    bus(16'hA000, 8'h00, 1'b0);
    expect_val("rst_basic_off", F_BAS, 32'd1);
    step();

    // RAMBO banking: DDRB=FF, select ORB, ORB=E3
    wr_cyc(16'hD301, 8'hFF);
    wr_cyc(16'hD303, 8'h04);
    bus(16'hD301, 8'hE3, 1'b1);
    expect_val("commit_next_cycle", F_PB, 32'h00);
    step();
    bus(16'h4123, 8'h00, 1'b0);
    expect_val("rambo_portb", F_PB, 32'hE3);
    expect_val("rambo_hit", F_HIT, 32'd1);
    expect_val("rambo_ra", F_RA, ra_bank(4'b1100, 16'h4123));
    step();
    bus(16'h8000, 8'h00, 1'b0);
    expect_val("outside_window_hit", F_HIT, 32'd0);
    expect_val("outside_window_ra", F_RA, 32'h08000);
    step();

    mode = 2'd2;
    bus(16'h4000, 8'h00, 1'b0);
`ifdef SRAMBO_AXLON_EN
    expect_val("mode2_axl_zero", F_HIT, 32'd0);
`else
    expect_val("mode2_as_rambo", F_HIT, 32'd1);
    expect_val("mode2_as_rambo_ra", F_RA, ra_bank(4'b1100, 16'h4000));
`endif
    step();
    mode = 2'd0;

    // Refresh and ANTIC writes are ignored
    bus(16'hD301, 8'h00, 1'b1);
    n_ref = 1'b0;
    expect_val("refresh_ci", F_CI, 32'd0);
    expect_val("refresh_io_gated", F_IO, 32'd1);
    step();
    bus(16'h4000, 8'h00, 1'b0);
    expect_val("refresh_write_ignored", F_PB, 32'hE3);
    step();
    bus(16'hD301, 8'h00, 1'b1);
    halt = 1'b0;
    step();
    bus(16'h4000, 8'h00, 1'b0);
    expect_val("antic_write_ignored", F_PB, 32'hE3);
    step();

    // Decode with OS on, BASIC off, self-test off
    wr_cyc(16'hD301, 8'hFF);
    bus(16'hD800, 8'h00, 1'b0);
    expect_val("math_os", F_OS, 32'd0);
    step();
    bus(16'hD800, 8'h00, 1'b0);
    n_mpd = 1'b0;
    expect_val("mpd_os", F_OS, 32'd1);
    expect_val("mpd_ci", F_CI, 32'd1);
    step();
    n_mpd = 1'b1;
    bus(16'hD000, 8'h00, 1'b0);
    expect_val("io_sel", F_IO, 32'd0);
    expect_val("io_os", F_OS, 32'd1);
    step();
    bus(16'h8000, 8'h00, 1'b0);
    rd4 = 1'b1;
    expect_val("s4_sel", F_S4, 32'd0);
    step();
    rd4 = 1'b0;
    bus(16'h9FFF, 8'h00, 1'b0);
    expect_val("s4_absent", F_S4, 32'd1);
    expect_val("s4_absent_ci", F_CI, 32'd1);
    step();
    bus(16'h5000, 8'h00, 1'b0);
    expect_val("st_off", F_OS, 32'd1);
    step();

    // OS on, BASIC on, self-test on
    wr_cyc(16'hD301, 8'h7D);
    bus(16'h5000, 8'h00, 1'b0);
    expect_val("st_on_os", F_OS, 32'd0);
    expect_val("st_on_hit", F_HIT, 32'd0);
    step();
    bus(16'hA000, 8'h00, 1'b0);
    expect_val("basic_on", F_BAS, 32'd0);
    expect_val("basic_on_ci", F_CI, 32'd0);
    step();
    bus(16'hBFFF, 8'h00, 1'b0);
    rd5 = 1'b1;
    expect_val("basic_cart_over", F_BAS, 32'd1);
    expect_val("s5_sel", F_S5, 32'd0);
    step();
    rd5 = 1'b0;

    // OS off
    wr_cyc(16'hD301, 8'hFC);
    bus(16'hE000, 8'h00, 1'b0);
    expect_val("os_off_e", F_OS, 32'd1);
    step();
    bus(16'hC000, 8'h00, 1'b0);
    expect_val("os_off_c", F_OS, 32'd1);
    expect_val("os_off_ci", F_CI, 32'd1);
    step();

    // Compy Shop: self-test state survives banking, CPU/ANTIC enables
    mode = 2'd1;
    wr_cyc(16'hD301, 8'h7F);
    bus(16'h5000, 8'h00, 1'b0);
    expect_val("compy_7f_hit", F_HIT, 32'd0);
    expect_val("compy_7f_st", F_OS, 32'd0);
    step();
    wr_cyc(16'hD301, 8'hEF);
    bus(16'h5000, 8'h00, 1'b0);
    expect_val("compy_ef_hit", F_HIT, 32'd1);
    expect_val("compy_ef_st_hidden", F_OS, 32'd1);
    expect_val("compy_ef_ra", F_RA, ra_bank(4'hF, 16'h5000));
    step();
    bus(16'h4000, 8'h00, 1'b0);
    halt = 1'b0;
    expect_val("compy_ef_cpu", F_HIT, 32'd1);
    step();
    bus(16'h4000, 8'h00, 1'b0);
    expect_val("compy_ef_antic", F_HIT, 32'd0);
    step();
    bus(16'h4000, 8'h00, 1'b0);
    expect_val("compy_ef_cpu_again", F_HIT, 32'd1);
    step();
    wr_cyc(16'hD301, 8'hDF);
    bus(16'h4000, 8'h00, 1'b0);
    halt = 1'b0;
    expect_val("compy_df_cpu", F_HIT, 32'd0);
    step();
    bus(16'h4000, 8'h00, 1'b0);
    expect_val("compy_df_antic", F_HIT, 32'd1);
    expect_val("compy_df_antic_ra", F_RA, ra_bank(4'hF, 16'h4000));
    step();
    bus(16'h5000, 8'h00, 1'b0);
    expect_val("compy_df_cpu_after", F_HIT, 32'd0);
    expect_val("compy_df_st_held", F_OS, 32'd0);
    step();
    mode = 2'd0;
    bus(16'h5000, 8'h00, 1'b0);
    expect_val("rambo_st_reload", F_OS, 32'd1);
    step();

    // Reset beats a concurrent write and drops the bank
    wr_cyc(16'hD301, 8'hE3);
    bus(16'h4000, 8'h00, 1'b0);
    expect_val("pre_reset_hit", F_HIT, 32'd1);
    step();
    bus(16'hD301, 8'h00, 1'b1);
    reset = 1'b1;
    step();
    bus(16'h4000, 8'h00, 1'b0);
    expect_val("reset_wins_portb", F_PB, 32'hFF);
    expect_val("reset_drops_bank", F_HIT, 32'd0);
    step();

    // After reset PBCTL=0, so $D301 reaches DDRB
    bus(16'hD301, 8'h0F, 1'b1);
    expect_val("ddrb_commit_next", F_PB, 32'hFF);
    step();
    bus(16'hE000, 8'h00, 1'b0);
    expect_val("ddrb_portb", F_PB, 32'hF0);
    expect_val("ddrb_os_off", F_OS, 32'd1);
    step();

`ifdef SRAMBO_AXLON_EN
    mode = 2'd2;
    wr_cyc(16'hCFFF, 8'h5A);
    bus(16'h4000, 8'h00, 1'b0);
    expect_val("axl_hit", F_HIT, 32'd1);
    expect_val("axl_ra", F_RA, ra_bank(8'h5A, 16'h4000));
    step();
    wr_cyc(16'hCFFF, 8'h00);
    bus(16'h4000, 8'h00, 1'b0);
    expect_val("axl_off", F_HIT, 32'd0);
    step();
`else
    mode = 2'd2;
    wr_cyc(16'hCFFF, 8'h5A);
    bus(16'h4000, 8'h00, 1'b0);
    expect_val("no_axl_reg", F_HIT, 32'd0);
    expect_val("no_axl_ra", F_RA, 32'h04000);
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
